// File: rtl/cpu_phase_sequencer.sv
// -----------------------------------------------------------------------------
// cpu_phase_sequencer
//
// Generates the two-phase core clock (phi) for a soft CPU core running from a
// much faster FPGA clock. Each phi half-phase lasts HALF_CYCLES clk cycles so
// the core's combinational netlist can settle. The phi-high half (PHI2) is
// stretched (WAIT_ACK) until the memory handshake started at the PHI1->PHI2
// edge has been acknowledged. The block also holds the core in reset for the
// first RESET_PHI phi cycles, synchronises the interrupt lines, and counts
// completed phi cycles.
//
// Ports
//   i_clk          FPGA clock, all flops on the rising edge
//   i_rst_n        asynchronous active-low reset
//   i_run          1 = keep generating phi cycles, 0 = park after this cycle
//   i_irq_n        asynchronous interrupt request, active-low
//   i_nmi_n        asynchronous non-maskable interrupt, active-low
//   i_core_ab      core address bus
//   i_core_rw      core read/write (1 = read)
//   i_core_dbo     core write data
//   i_mem_ack      memory acknowledge (only looked at while o_mem_req = 1)
//   i_mem_rdata    memory read data
//   o_phi          core clock
//   o_core_res     core reset, active-low
//   o_core_irq     synchronised interrupt to core, active-low
//   o_core_nmi     synchronised NMI to core, active-low
//   o_core_dbi     read data presented to the core
//   o_mem_req      memory request, one per phi cycle
//   o_mem_we       memory write enable
//   o_mem_addr     memory address
//   o_mem_wdata    memory write data
//   o_cycle_count  completed phi cycles since reset (wraps)
// -----------------------------------------------------------------------------
module cpu_phase_sequencer #(
    parameter int HALF_CYCLES = 8,
    parameter int RESET_PHI   = 8,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_run,
    input  logic             i_irq_n,
    input  logic             i_nmi_n,
    input  logic [15:0]      i_core_ab,
    input  logic             i_core_rw,
    input  logic [7:0]       i_core_dbo,
    input  logic             i_mem_ack,
    input  logic [7:0]       i_mem_rdata,
    output logic             o_phi,
    output logic             o_core_res,
    output logic             o_core_irq,
    output logic             o_core_nmi,
    output logic [7:0]       o_core_dbi,
    output logic             o_mem_req,
    output logic             o_mem_we,
    output logic [15:0]      o_mem_addr,
    output logic [7:0]       o_mem_wdata,
    output logic [CNT_W-1:0] o_cycle_count
);

    localparam int HC_W = $clog2(HALF_CYCLES);
    localparam int RP_W = $clog2(RESET_PHI + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PHI1 = 2'd1,
        ST_PHI2 = 2'd2,
        ST_WAIT = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [HC_W-1:0]        r_hcnt;
    logic [HC_W-1:0]        w_hcnt_nxt;
    logic                   w_hcnt_zero;
    logic                   w_ack_take;
    logic                   w_launch;
    logic                   w_enter_phi1;
    logic                   w_cycle_end;
    logic                   w_phi_nxt;
    logic                   r_phi;

    logic                   r_mem_req;
    logic                   r_mem_we;
    logic [15:0]            r_mem_addr;
    logic [7:0]             r_mem_wdata;
    logic [7:0]             r_core_dbi;

    logic [CNT_W-1:0]       r_cycle_count;
    logic [RP_W-1:0]        r_rst_cnt;
    logic [RP_W-1:0]        w_rst_cnt_nxt;
    logic                   r_core_res;

    logic [SYNC_STAGES-1:0] r_irq_sync;
    logic [SYNC_STAGES-1:0] r_nmi_sync;
    logic                   r_core_irq;
    logic                   r_core_nmi;

    assign w_hcnt_zero = (r_hcnt == '0);
    // An ack only counts while a request is outstanding; stray acks are ignored.
    assign w_ack_take  = r_mem_req & i_mem_ack;

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: run is only consulted at cycle boundaries, so dropping
    // it mid-cycle lets the current cycle and its handshake finish.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_run) begin
                    w_state_nxt = ST_PHI1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_PHI1: begin
                if (w_hcnt_zero) begin
                    w_state_nxt = ST_PHI2;
                end else begin
                    w_state_nxt = ST_PHI1;
                end
            end
            ST_PHI2: begin
                // mem_req already low in PHI2 means the ack was taken earlier.
                if (w_hcnt_zero && (!r_mem_req || i_mem_ack)) begin
                    w_state_nxt = i_run ? ST_PHI1 : ST_IDLE;
                end else if (w_hcnt_zero) begin
                    w_state_nxt = ST_WAIT;
                end else begin
                    w_state_nxt = ST_PHI2;
                end
            end
            ST_WAIT: begin
                if (w_ack_take) begin
                    w_state_nxt = i_run ? ST_PHI1 : ST_IDLE;
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output/decode logic derived from the current and next state.
    always_comb begin
        w_phi_nxt    = (w_state_nxt == ST_PHI2) || (w_state_nxt == ST_WAIT);
        w_launch     = (r_state == ST_PHI1) && w_hcnt_zero;
        w_enter_phi1 = (w_state_nxt == ST_PHI1) && (r_state != ST_PHI1);
        w_cycle_end  = ((r_state == ST_PHI2) || (r_state == ST_WAIT)) &&
                       ((w_state_nxt == ST_PHI1) || (w_state_nxt == ST_IDLE));
        // Reload on every state change; only the two timed halves count down.
        if (w_state_nxt != r_state) begin
            w_hcnt_nxt = HC_W'(HALF_CYCLES - 1);
        end else if ((r_state == ST_PHI1) || (r_state == ST_PHI2)) begin
            w_hcnt_nxt = r_hcnt - HC_W'(1);
        end else begin
            w_hcnt_nxt = r_hcnt;
        end
        // Reset-hold counter saturates at RESET_PHI.
        if (w_cycle_end && (r_rst_cnt != RP_W'(RESET_PHI))) begin
            w_rst_cnt_nxt = r_rst_cnt + RP_W'(1);
        end else begin
            w_rst_cnt_nxt = r_rst_cnt;
        end
    end

    // Half-phase counter and registered phi.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hcnt <= HC_W'(HALF_CYCLES - 1);
            r_phi  <= 1'b0;
        end else begin
            r_hcnt <= w_hcnt_nxt;
            r_phi  <= w_phi_nxt;
        end
    end

    // Memory request: launched at the phi rising edge, dropped on ack; read
    // data is captured into core_dbi only for reads.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 16'h0000;
            r_mem_wdata <= 8'h00;
            r_core_dbi  <= 8'h00;
        end else if (w_launch) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= ~i_core_rw;
            r_mem_addr  <= i_core_ab;
            r_mem_wdata <= i_core_dbo;
        end else if (w_ack_take) begin
            r_mem_req <= 1'b0;
            if (!r_mem_we) begin
                r_core_dbi <= i_mem_rdata;
            end
        end
    end

    // Completed-cycle counter, reset-hold counter and core reset release.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cycle_count <= '0;
            r_rst_cnt     <= '0;
            r_core_res    <= 1'b0;
        end else begin
            r_rst_cnt <= w_rst_cnt_nxt;
            if (w_cycle_end) begin
                r_cycle_count <= r_cycle_count + CNT_W'(1);
            end
            if (w_enter_phi1 && (w_rst_cnt_nxt == RP_W'(RESET_PHI))) begin
                r_core_res <= 1'b1;
            end
        end
    end

    // Interrupt synchronisers; the core only sees a new value at PHI1 entry so
    // its inputs never change within a phi cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_irq_sync <= '1;
            r_nmi_sync <= '1;
            r_core_irq <= 1'b1;
            r_core_nmi <= 1'b1;
        end else begin
            r_irq_sync <= {r_irq_sync[SYNC_STAGES-2:0], i_irq_n};
            r_nmi_sync <= {r_nmi_sync[SYNC_STAGES-2:0], i_nmi_n};
            if (w_enter_phi1) begin
                r_core_irq <= r_irq_sync[SYNC_STAGES-1];
                r_core_nmi <= r_nmi_sync[SYNC_STAGES-1];
            end
        end
    end

    assign o_phi         = r_phi;
    assign o_core_res    = r_core_res;
    assign o_core_irq    = r_core_irq;
    assign o_core_nmi    = r_core_nmi;
    assign o_core_dbi    = r_core_dbi;
    assign o_mem_req     = r_mem_req;
    assign o_mem_we      = r_mem_we;
    assign o_mem_addr    = r_mem_addr;
    assign o_mem_wdata   = r_mem_wdata;
    assign o_cycle_count = r_cycle_count;

endmodule
